// File: rtl/frame_write_pkg.sv
// frame_write_pkg: shared types and constants for the frame write path.
//   state_t    : controller FSM states
//   RESP_OKAY  : write response code for a successful burst
//   WORD_BYTES : bytes per 64-bit stream word
package frame_write_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ADDR,
    S_DATA,
    S_RESP,
    S_NEXT
  } state_t;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam int         WORD_BYTES = 8;

endpackage

// File: rtl/frame_write_ctrl_if.sv
// frame_write_ctrl_if: memory write port (address, data and response channels).
//   master : burst issuer (drives aw*, w*, bready)
//   slave  : memory side (drives awready, wready, bvalid, bresp)
interface frame_write_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic              awvalid;
  logic              awready;
  logic [63:0]       wdata;
  logic              wvalid;
  logic              wlast;
  logic              wready;
  logic              bvalid;
  logic [1:0]        bresp;
  logic              bready;

  modport master (
    output awaddr, awlen, awvalid, wdata, wvalid, wlast, bready,
    input  awready, wready, bvalid, bresp
  );

  modport slave (
    input  awaddr, awlen, awvalid, wdata, wvalid, wlast, bready,
    output awready, wready, bvalid, bresp
  );
endinterface

// File: rtl/frame_write_ctrl_burst_sizer.sv
// burst_sizer: combinational sizing of the next burst.
//   remaining      : words still to write in the current frame
//   addr           : byte address of the next burst
//   beats          : min(remaining, BURST_LEN)
//   awlen          : beats-1 (bus encoding)
//   addr_next      : address after this burst (wraps modulo 2^ADDR_W)
//   remaining_next : words left after this burst
module burst_sizer
  import frame_write_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int WORDS_W   = 24,
  parameter int BURST_LEN = 16
) (
  input  logic [WORDS_W-1:0] remaining,
  input  logic [ADDR_W-1:0]  addr,
  output logic [8:0]         beats,
  output logic [7:0]         awlen,
  output logic [ADDR_W-1:0]  addr_next,
  output logic [WORDS_W-1:0] remaining_next
);

  localparam logic [WORDS_W-1:0] BURST_WORDS = WORDS_W'(BURST_LEN);

  always_comb begin
    if (remaining < BURST_WORDS) beats = remaining[8:0];
    else                         beats = 9'(BURST_LEN);
    awlen          = 8'(beats - 9'd1);
    remaining_next = remaining - WORDS_W'(beats);
    addr_next      = addr + ADDR_W'(beats) * ADDR_W'(WORD_BYTES);
  end

endmodule

// File: rtl/frame_write_ctrl.sv
// frame_write_ctrl: drains the 64-bit stream buffer into frame memory as
// fixed-length bursts, one outstanding at a time, rotating over NUM_BUFS
// frame buffers.
//   clk, rst                      : clock, asynchronous active-high reset
//   start, stop                   : begin capture / finish current frame then idle
//   frame_base, buf_stride,
//   frame_words                   : frame geometry, sampled at each frame start
//   fifo_dout/valid/level/ready   : stream buffer read side
//   mem                           : memory write port (master)
//   busy, frame_done, buf_idx,
//   error                         : status
module frame_write_ctrl
  import frame_write_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int WORDS_W   = 24,
  parameter int BURST_LEN = 16,
  parameter int NUM_BUFS  = 2,
  parameter int LEVEL_W   = 11,
  localparam int BUF_W    = (NUM_BUFS > 1) ? $clog2(NUM_BUFS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic [ADDR_W-1:0]   frame_base,
  input  logic [ADDR_W-1:0]   buf_stride,
  input  logic [WORDS_W-1:0]  frame_words,
  input  logic [63:0]         fifo_dout,
  input  logic                fifo_valid,
  input  logic [LEVEL_W-1:0]  fifo_level,
  output logic                fifo_ready,
  frame_write_ctrl_if.master  mem,
  output logic                busy,
  output logic                frame_done,
  output logic [BUF_W-1:0]    buf_idx,
  output logic                error
);

  state_t             state;
  logic [WORDS_W-1:0] remaining;
  logic [ADDR_W-1:0]  addr;
  logic [7:0]         beat_cnt;
  logic               stop_flag;
  logic               error_r;
  logic [BUF_W-1:0]   buf_idx_r;
  logic               frame_done_r;
  logic               awvalid_r;
  logic [ADDR_W-1:0]  awaddr_r;
  logic [7:0]         awlen_r;
  logic               bready_r;

  logic [8:0]         sz_beats;
  logic [7:0]         sz_awlen;
  logic [ADDR_W-1:0]  sz_addr_next;
  logic [WORDS_W-1:0] sz_rem_next;

  logic               in_data;
  logic               beat_xfer;
  logic               last_beat;
  logic [BUF_W-1:0]   buf_next;

  burst_sizer #(
    .ADDR_W    (ADDR_W),
    .WORDS_W   (WORDS_W),
    .BURST_LEN (BURST_LEN)
  ) u_sizer (
    .remaining      (remaining),
    .addr           (addr),
    .beats          (sz_beats),
    .awlen          (sz_awlen),
    .addr_next      (sz_addr_next),
    .remaining_next (sz_rem_next)
  );

  function automatic logic [BUF_W-1:0] next_buf(input logic [BUF_W-1:0] cur);
    if (cur == BUF_W'(NUM_BUFS - 1)) return '0;
    return cur + BUF_W'(1);
  endfunction

  // Data beats pass straight through from the stream buffer; a burst is only
  // issued once the buffer holds all its words, so gaps here are brief.
  assign in_data    = (state == S_DATA);
  assign beat_xfer  = in_data & fifo_valid & mem.wready;
  assign last_beat  = in_data & (beat_cnt == awlen_r);
  assign buf_next   = next_buf(buf_idx_r);

  assign fifo_ready  = beat_xfer;
  assign mem.wvalid  = in_data & fifo_valid;
  assign mem.wdata   = fifo_dout;
  assign mem.wlast   = last_beat;
  assign mem.awvalid = awvalid_r;
  assign mem.awaddr  = awaddr_r;
  assign mem.awlen   = awlen_r;
  assign mem.bready  = bready_r;

  assign busy       = (state != S_IDLE);
  assign frame_done = frame_done_r;
  assign buf_idx    = buf_idx_r;
  assign error      = error_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      remaining    <= '0;
      addr         <= '0;
      beat_cnt     <= '0;
      stop_flag    <= 1'b0;
      error_r      <= 1'b0;
      buf_idx_r    <= '0;
      frame_done_r <= 1'b0;
      awvalid_r    <= 1'b0;
      awaddr_r     <= '0;
      awlen_r      <= '0;
      bready_r     <= 1'b0;
    end else begin
      frame_done_r <= 1'b0;
      // A stop request is remembered for the whole frame; the branches below
      // clear it whenever a new frame begins.
      if (state != S_IDLE && stop) stop_flag <= 1'b1;

      unique case (state)
        S_IDLE: begin
          if (start) begin
            if (frame_words == '0) begin
              error_r <= 1'b1;
            end else begin
              error_r   <= 1'b0;
              buf_idx_r <= '0;
              remaining <= frame_words;
              addr      <= frame_base;
              stop_flag <= 1'b0;
              state     <= S_WAIT;
            end
          end
        end

        S_WAIT: begin
          if (32'(fifo_level) >= 32'(sz_beats)) begin
            awaddr_r  <= addr;
            awlen_r   <= sz_awlen;
            awvalid_r <= 1'b1;
            state     <= S_ADDR;
          end
        end

        S_ADDR: begin
          if (mem.awready) begin
            awvalid_r <= 1'b0;
            beat_cnt  <= '0;
            state     <= S_DATA;
          end
        end

        S_DATA: begin
          if (beat_xfer) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (last_beat) begin
              bready_r <= 1'b1;
              state    <= S_RESP;
            end
          end
        end

        S_RESP: begin
          if (mem.bvalid) begin
            bready_r  <= 1'b0;
            if (mem.bresp != RESP_OKAY) error_r <= 1'b1;
            remaining <= sz_rem_next;
            addr      <= sz_addr_next;
            if (sz_rem_next == '0) begin
              frame_done_r <= 1'b1;
              state        <= S_NEXT;
            end else begin
              state <= S_WAIT;
            end
          end
        end

        S_NEXT: begin
          buf_idx_r <= buf_next;
          // A stop arriving in this very cycle still ends capture here.
          if (stop_flag || stop) begin
            stop_flag <= 1'b0;
            state     <= S_IDLE;
          end else if (frame_words == '0) begin
            error_r <= 1'b1;
            state   <= S_IDLE;
          end else begin
            addr      <= frame_base + ADDR_W'(buf_next) * buf_stride;
            remaining <= frame_words;
            stop_flag <= 1'b0;
            state     <= S_WAIT;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/frame_write_ctrl.md
Name: frame_write_ctrl

Overview:
- Drains the 64-bit stream buffer FIFO into frame memory as fixed-length write bursts.
- Sequences whole frames and rotates through NUM_BUFS frame buffers (multi-buffering).
- Sits between the camera stream buffer output and the memory write port.
- One burst outstanding at a time. A burst is issued only when the FIFO already holds its full length, so the write data never stalls mid-burst.

Parameters:
ADDR_W, 32, byte address width
WORDS_W, 24, width of frame size in 64-bit words
BURST_LEN, 16, max beats per burst (power of 2, ≤256)
NUM_BUFS, 2, number of frame buffers rotated through
LEVEL_W, 11, width of FIFO occupancy input

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  pulse; begin capturing frames
stop  in  1  pulse; finish current frame, then idle
frame_base  in  ADDR_W  byte address of buffer 0, BURST_LEN*8 aligned
buf_stride  in  ADDR_W  byte distance between buffers
frame_words  in  WORDS_W  64-bit words per frame
fifo_dout  in  64  stream buffer data
fifo_valid  in  1  stream buffer not empty
fifo_level  in  LEVEL_W  stream buffer occupancy in words
fifo_ready  out  1  read strobe to stream buffer
awaddr  out  ADDR_W  burst byte address
awlen  out  8  beats-1
awvalid  out  1  address valid
awready  in  1  address accepted
wdata  out  64  write data
wvalid  out  1  write data valid
wlast  out  1  last beat of burst
wready  in  1  write data accepted
bvalid  in  1  write response valid
bresp  in  2  response code, 0 = OK
bready  out  1  response accept
busy  out  1  not IDLE
frame_done  out  1  one-cycle pulse per completed frame
buf_idx  out  clog2(NUM_BUFS)  buffer currently being written
error  out  1  sticky error flag, cleared by start

Behaviour:
- Reset: state IDLE. All outputs 0: awvalid, wvalid, bready, fifo_ready, frame_done, busy, error, buf_idx, awaddr, awlen, wlast.
- Configuration inputs are sampled on frame start. They may change freely during a frame.
- States: IDLE, WAIT, ADDR, DATA, RESP, NEXT.
- IDLE:
  - start with frame_words≠0 → clear error, buf_idx=0, load remaining=frame_words, addr=frame_base, go to WAIT.
  - start with frame_words=0 → set error, stay IDLE.
- WAIT:
  - beats = min(remaining, BURST_LEN).
  - When fifo_level ≥ beats → drive awaddr=addr, awlen=beats-1, awvalid=1, go to ADDR.
- ADDR:
  - Hold awvalid and all address fields stable until awready.
  - Then → DATA with beat counter = 0.
- DATA:
  - wvalid = fifo_valid. wdata = fifo_dout (combinational pass-through).
  - fifo_ready = wready & fifo_valid.
  - A beat transfers when wvalid & wready. wlast = 1 on beat beats-1.
  - After the last beat → RESP.
  - A new burst's address is never issued before the previous burst's data completes.
- RESP:
  - bready = 1. On bvalid: bresp≠0 sets error (sticky); the transfer continues regardless.
  - remaining -= beats; addr += beats*8.
  - remaining=0 → NEXT; otherwise → WAIT.
- NEXT:
  - Pulse frame_done for one cycle.
  - buf_idx = (buf_idx+1) mod NUM_BUFS.
  - stop seen since frame start → IDLE.
  - Otherwise: addr = frame_base + buf_idx_new*buf_stride, remaining = frame_words (resampled); frame_words=0 here sets error and goes to IDLE.
  - Otherwise → WAIT.
- stop is latched into a flag at any time while busy. A stop pulse in IDLE is ignored. start while busy is ignored.
- A short final burst (remaining < BURST_LEN) uses awlen=remaining-1.
- Address arithmetic wraps modulo 2^ADDR_W.
- busy = state≠IDLE.
- Latency: awvalid rises at least 1 cycle after fifo_level reaches beats. NEXT lasts exactly 1 cycle.
- A rst assertion mid-burst aborts immediately to the reset state. Frame memory contents are then undefined; no recovery is attempted.

Decomposition:
- Package frame_write_pkg: state enum, OKAY response constant (2'b00), WORD_BYTES=8.
- Sub-module burst_sizer: computes beats/awlen from remaining and BURST_LEN, and the next address/remaining. Purely combinational; kept separate so it can be reused by the read-side controller.

Test Plan:
- frame_words=40, BURST_LEN=16, FIFO pre-filled, awready/wready always 1, frame_base=0x1000 → bursts at 0x1000/0x1080/0x1100 with awlen 15/15/7; wlast on beats 16/16/8; one frame_done pulse; buf_idx 0→1.
- FIFO level held at 15 with BURST_LEN=16 → no awvalid; adding 1 word → awvalid within 1 cycle.
- wready toggled randomly, fifo_valid gaps → every word delivered once, in order; wdata matches FIFO sequence; no beat is lost or duplicated.
- Continuous capture, NUM_BUFS=2, buf_stride=0x10000, 3 frames → frame bases 0x1000, 0x11000, 0x1000; stop during frame 3 → IDLE after its frame_done.
- bresp=2 on the 2nd burst → error=1 stays set; frame still completes; next start clears error.
- start with frame_words=0 → error=1, busy stays 0. rst mid-DATA → all outputs 0 on the next edge.
